ahb_arbiter: RTL and testbench

Round-robin AHB bus arbiter for a multi-master AHB matrix. It takes per-master bus requests and lock requests, plus the transfer-control and response signals of the current address-phase owner. From these it produces the one-hot grant vector and the registered Hmaster index. Hmaster steers both the master-to-slave request mux and the slave_to_master_mux read-data/response routing, so this block sits directly upstream of slave_to_master_mux. Fixed-length bursts and locked sequences are never broken.

---
 rtl/ahb_arbiter.sv | 142 ++++++++++++++
 tb/tb_ahb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter that never breaks fixed bursts or locked sequences.
// Hgrant, Hmaster and Hmastlock are all registered on Hclk.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_WIDTH   = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                    Hclk,
    input  logic                    Hreset,
    input  logic [NUM_MASTERS-1:0]  Hbusreq,
    input  logic [NUM_MASTERS-1:0]  Hlock,
    input  logic [1:0]              Htrans,
    input  logic [2:0]              Hburst,
    input  logic                    Hready,
    input  logic [1:0]              Hresp,
    output logic [NUM_MASTERS-1:0]  Hgrant,
    output logic [MASTER_WIDTH-1:0] Hmaster,
    output logic                    Hmastlock
);

    typedef enum logic [2:0] {PARK, OWN, BURST, INCRB, LOCK} state_t;

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
        NUM_MASTERS'(1) << DEFAULT_MASTER;

    state_t                  state, state_nxt, eff;
    logic [3:0]              beat_cnt, beat_nxt, eff_cnt;
    logic [MASTER_WIDTH-1:0] rr, rr_nxt, win, cand, gnt_idx;
    logic [NUM_MASTERS-1:0]  grant_nxt;
    logic                    nonseq, seq, err, hold, arb, found;

    function automatic logic [3:0] burst_len(input logic [2:0] b);
        logic [3:0] len;
        unique case (b[2:1])
            2'b01:   len = 4'd3;
            2'b10:   len = 4'd7;
            2'b11:   len = 4'd15;
            default: len = 4'd0;
        endcase
        return len;
    endfunction

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (Hgrant[i]) gnt_idx = MASTER_WIDTH'(i);
    end

    always_comb begin
        found = 1'b0;
        win   = rr;
        cand  = rr;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = MASTER_WIDTH'((int'(rr) + k) % NUM_MASTERS);
            if (!found && Hbusreq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // A NONSEQ starting a burst or lock is judged as if already inside it.
    always_comb begin
        nonseq  = (Htrans == 2'b10);
        seq     = (Htrans == 2'b11);
        err     = (Hresp == 2'b01);
        eff     = state;
        eff_cnt = beat_cnt;
        if (nonseq) begin
            eff_cnt = burst_len(Hburst);
            if (Hlock[Hmaster])
                eff = LOCK;
            else if (Hburst[2:1] != 2'b00)
                eff = BURST;
            else if (Hburst[0])
                eff = INCRB;
            else
                eff = OWN;
        end
    end

    always_comb begin
        hold = 1'b0;
        unique case (eff)
            BURST:   hold = !((eff_cnt == 4'd0) ||
                              (eff_cnt == 4'd1 && seq));
            INCRB:   hold = Hbusreq[Hmaster];
            LOCK:    hold = Hlock[Hmaster];
            default: hold = 1'b0;
        endcase
        arb = Hready &&
              (!hold || (err && !(state == LOCK && Hlock[Hmaster])));
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        rr_nxt    = rr;
        grant_nxt = Hgrant;
        if (Hready) begin
            if (err)
                beat_nxt = 4'd0;
            else if (nonseq)
                beat_nxt = burst_len(Hburst);
            else if (seq && beat_cnt != 4'd0)
                beat_nxt = beat_cnt - 4'd1;
            if (nonseq)
                state_nxt = eff;
        end
        if (arb) begin
            if (found) begin
                grant_nxt = NUM_MASTERS'(1) << win;
                rr_nxt    = win;
                state_nxt = OWN;
            end else begin
                grant_nxt = DEF_GRANT;
                state_nxt = PARK;
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state     <= PARK;
            beat_cnt  <= 4'd0;
            rr        <= MASTER_WIDTH'(DEFAULT_MASTER);
            Hgrant    <= DEF_GRANT;
            Hmaster   <= MASTER_WIDTH'(DEFAULT_MASTER);
            Hmastlock <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            rr       <= rr_nxt;
            Hgrant   <= grant_nxt;
            if (Hready) begin
                Hmaster   <= gnt_idx;
                Hmastlock <= Hlock[gnt_idx];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: table vectors, directed burst/lock/error sequences,
// and random traffic against a behavioural arbitration model.
module tb_ahb_arbiter;

    localparam int N = 4;
    localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;
    localparam logic [2:0] INCR8 = 3'b101, INCR16 = 3'b111;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b01;
    localparam int K_FREE = 0, K_FIXED = 1, K_UNDEF = 2, K_LOCK = 3;

    logic       Hclk = 1'b0;
    logic       Hreset;
    logic [3:0] Hbusreq, Hlock;
    logic [1:0] Htrans;
    logic [2:0] Hburst;
    logic       Hready;
    logic [1:0] Hresp;
    logic [3:0] Hgrant;
    logic [1:0] Hmaster;
    logic       Hmastlock;

    int passed = 0;
    int total  = 0;
    bit chk_on = 1'b0;
    bit use_model = 1'b0;

    logic [1:0] m_gnt, m_mst, m_rr;
    logic       m_mlk;
    int         m_left, m_kind;

    always #5 Hclk = ~Hclk;

    ahb_arbiter #(.NUM_MASTERS(4), .MASTER_WIDTH(2), .DEFAULT_MASTER(0)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hbusreq(Hbusreq), .Hlock(Hlock),
        .Htrans(Htrans), .Hburst(Hburst), .Hready(Hready), .Hresp(Hresp),
        .Hgrant(Hgrant), .Hmaster(Hmaster), .Hmastlock(Hmastlock)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge Hclk)
        if (chk_on) check("onehot", 32'($onehot(Hgrant)), 32'd1);

    function automatic int beats(input logic [2:0] b);
        if (b >= 3'd6) return 16;
        if (b >= 3'd4) return 8;
        if (b >= 3'd2) return 4;
        return 1;
    endfunction

    task automatic model_step();
        logic [1:0] own, cand;
        int  kind, left;
        bit  hold, arb, found;
        if (Hreset) begin
            m_gnt = 0; m_mst = 0; m_rr = 0; m_mlk = 0;
            m_left = 0; m_kind = K_FREE;
            return;
        end
        if (!Hready) return;
        own  = m_mst;
        kind = m_kind;
        left = m_left;
        if (Htrans == NSQ) begin
            left = beats(Hburst) - 1;
            if (Hlock[own]) kind = K_LOCK;
            else if (Hburst == SINGLE) kind = K_FREE;
            else if (Hburst == 3'b001) kind = K_UNDEF;
            else kind = K_FIXED;
        end
        // may the bus change hands after this beat?
        case (kind)
            K_FIXED: hold = left > 1 || (left == 1 && Htrans != SEQ);
            K_UNDEF: hold = Hbusreq[own];
            K_LOCK:  hold = Hlock[own];
            default: hold = 1'b0;
        endcase
        arb = !hold || (Hresp == ERR && !(m_kind == K_LOCK && Hlock[own]));
        m_mst = m_gnt;
        m_mlk = Hlock[m_gnt];
        if (Hresp == ERR) m_left = 0;
        else if (Htrans == NSQ) m_left = left;
        else if (Htrans == SEQ && m_left > 0) m_left--;
        m_kind = arb ? K_FREE : kind;
        if (arb) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = 2'((int'(m_rr) + k) % N);
                if (!found && Hbusreq[cand]) begin
                    found = 1'b1;
                    m_gnt = cand;
                    m_rr  = cand;
                end
            end
            if (!found) m_gnt = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Hclk);
        #1;
        if (use_model) begin
            check("rnd_grant", 32'(Hgrant), 32'(4'(1) << m_gnt));
            check("rnd_master", 32'(Hmaster), 32'(m_mst));
            check("rnd_mastlock", 32'(Hmastlock), 32'(m_mlk));
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] br,
                         input logic [3:0] lk, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rd,
                         input logic [1:0] rs);
        Hreset = rst; Hbusreq = br; Hlock = lk;
        Htrans = tr; Hburst = bu; Hready = rd; Hresp = rs;
    endtask

    task automatic step(input logic [3:0] br, input logic [3:0] lk,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rd, input logic [1:0] rs);
        drive(1'b0, br, lk, tr, bu, rd, rs);
        tick();
    endtask

    task automatic exp3(input string tag, input logic [3:0] g,
                        input logic [1:0] m, input logic ml);
        check({tag, "_grant"}, 32'(Hgrant), 32'(g));
        check({tag, "_master"}, 32'(Hmaster), 32'(m));
        check({tag, "_mastlock"}, 32'(Hmastlock), 32'(ml));
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0, 4'b0, IDLE, SINGLE, 1'b1, OK);
        tick();
        tick();
    endtask

    // master 1 becomes owner with no competition
    task automatic take_m1();
        step(4'b0010, 4'b0, IDLE, SINGLE, 1'b1, OK);
        exp3("own0", 4'b0010, 2'd0, 1'b0);
        step(4'b0010, 4'b0, IDLE, SINGLE, 1'b1, OK);
        exp3("own1", 4'b0010, 2'd1, 1'b0);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] br;
        logic [1:0] tr;
        logic [3:0] eg;
        logic [1:0] em;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] br,
                                input logic [1:0] tr, input logic [3:0] eg,
                                input logic [1:0] em);
        vec_t v;
        v.rst = rst; v.br = br; v.tr = tr; v.eg = eg; v.em = em;
        return v;
    endfunction

    vec_t tab[12];

    initial begin
        tab[0]  = mk(1'b1, 4'b0000, IDLE, 4'b0001, 2'd0);
        tab[1]  = mk(1'b1, 4'b0000, IDLE, 4'b0001, 2'd0);
        for (int i = 2; i < 7; i++)
            tab[i] = mk(1'b0, 4'b0000, IDLE, 4'b0001, 2'd0);
        tab[7]  = mk(1'b0, 4'b0110, NSQ, 4'b0010, 2'd0);
        tab[8]  = mk(1'b0, 4'b0110, NSQ, 4'b0100, 2'd1);
        tab[9]  = mk(1'b0, 4'b0110, NSQ, 4'b0010, 2'd2);
        tab[10] = mk(1'b0, 4'b0110, NSQ, 4'b0100, 2'd1);
        tab[11] = mk(1'b0, 4'b0110, NSQ, 4'b0010, 2'd2);

        drive(1'b1, 4'b0, 4'b0, IDLE, SINGLE, 1'b1, OK);
        for (int i = 0; i < 12; i++) begin
            drive(tab[i].rst, tab[i].br, 4'b0, tab[i].tr, SINGLE, 1'b1, OK);
            tick();
            chk_on = 1'b1;
            exp3($sformatf("vec%0d", i), tab[i].eg, tab[i].em, 1'b0);
        end

        do_reset();
        take_m1();
        step(4'b1010, 4'b0, NSQ, INCR4, 1'b1, OK);
        exp3("b4_nseq", 4'b0010, 2'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(4'b1010, 4'b0, SEQ, INCR4, 1'b1, OK);
            check("b4_hold", 32'(Hgrant), 32'(4'b0010));
        end
        step(4'b1010, 4'b0, SEQ, INCR4, 1'b1, OK);
        exp3("b4_last", 4'b1000, 2'd1, 1'b0);
        step(4'b1000, 4'b0, IDLE, SINGLE, 1'b1, OK);
        exp3("b4_after", 4'b1000, 2'd3, 1'b0);

        do_reset();
        take_m1();
        step(4'b1010, 4'b0, NSQ, INCR4, 1'b1, OK);
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 4'b0, SEQ, INCR4, 1'b0, OK);
            exp3("stall", 4'b0010, 2'd1, 1'b0);
            check("stall_cnt", 32'(dut.beat_cnt), 32'd3);
        end
        for (int i = 0; i < 2; i++) begin
            step(4'b1010, 4'b0, SEQ, INCR4, 1'b1, OK);
            check("stall_hold", 32'(Hgrant), 32'(4'b0010));
        end
        step(4'b1010, 4'b0, SEQ, INCR4, 1'b1, OK);
        exp3("stall_last", 4'b1000, 2'd1, 1'b0);

        do_reset();
        step(4'b0100, 4'b0100, IDLE, SINGLE, 1'b1, OK);
        exp3("lk0", 4'b0100, 2'd0, 1'b0);
        step(4'b0100, 4'b0100, IDLE, SINGLE, 1'b1, OK);
        exp3("lk1", 4'b0100, 2'd2, 1'b1);
        step(4'b1111, 4'b0100, NSQ, INCR8, 1'b1, OK);
        exp3("lk_nseq", 4'b0100, 2'd2, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(4'b1111, 4'b0100, SEQ, INCR8, 1'b1, OK);
            exp3("lk_seq", 4'b0100, 2'd2, 1'b1);
        end
        step(4'b1111, 4'b0100, NSQ, SINGLE, 1'b1, OK);
        exp3("lk_single", 4'b0100, 2'd2, 1'b1);
        step(4'b1011, 4'b0000, IDLE, SINGLE, 1'b1, OK);
        exp3("lk_drop", 4'b1000, 2'd2, 1'b0);
        step(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, OK);
        exp3("lk_after", 4'b1000, 2'd3, 1'b0);

        do_reset();
        take_m1();
        step(4'b1010, 4'b0, NSQ, INCR16, 1'b1, OK);
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 4'b0, SEQ, INCR16, 1'b1, OK);
            check("e16_hold", 32'(Hgrant), 32'(4'b0010));
        end
        check("e16_cnt", 32'(dut.beat_cnt), 32'd12);
        step(4'b1010, 4'b0, SEQ, INCR16, 1'b1, ERR);
        exp3("e16_err", 4'b1000, 2'd1, 1'b0);
        check("e16_clr", 32'(dut.beat_cnt), 32'd0);
        step(4'b1000, 4'b0, IDLE, SINGLE, 1'b1, OK);
        exp3("e16_after", 4'b1000, 2'd3, 1'b0);

        do_reset();
        use_model = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 199) == 0,
                  4'($urandom),
                  4'($urandom) & 4'($urandom) & 4'($urandom),
                  2'($urandom), 3'($urandom),
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 19) == 0) ? ERR : OK);
            tick();
        end
        use_model = 1'b0;
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
